beat_sequencer: RTL and testbench

- Schedules the metronome bell: converts the 8-bit BPM value from the tempo-adjust logic into beat instants, tracks position within a bar, and gates a tone generator onto the bell output.
- Normal beats sound a short low tone. Beat 0 of each bar sounds an accented high tone.
- Sits between the speed/play sources and the bell pin, and also exports the beat index for the 7-segment display path.

---
 rtl/beat_sequencer_pkg.sv | 20 ++
 rtl/beat_sequencer_bell_tone_gen.sv | 51 +++++
 rtl/beat_sequencer.sv | 121 ++++++++++++
 tb/tb_beat_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/beat_sequencer_pkg.sv
// beat_sequencer_pkg: shared widths, clamp bounds, state encoding and bar-length sanitiser
package beat_sequencer_pkg;

    localparam int ACC_W = 34;
    localparam int BPM_MIN_DEF = 30;
    localparam int BPM_MAX_DEF = 250;
    localparam logic [3:0] BPB_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } state_t;

    // 0 means a one-beat bar; anything past nine is capped at nine
    function automatic logic [3:0] sanitize_bpb(input logic [3:0] b);
        return (b == 4'd0) ? 4'd1 : (b > BPB_MAX) ? BPB_MAX : b;
    endfunction

endpackage

// File: rtl/beat_sequencer_bell_tone_gen.sv
// beat_sequencer_bell_tone_gen: gated square-wave burst generator driving the bell pin
module beat_sequencer_bell_tone_gen #(
    parameter int BELL_CYC    = 5_000_000,
    parameter int TONE_HALF   = 50_000,
    parameter int ACCENT_HALF = 25_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clr,
    input  logic hi,
    output logic bell
);

    localparam int CW   = $clog2(BELL_CYC + 1);
    localparam int HMAX = (TONE_HALF > ACCENT_HALF) ? TONE_HALF : ACCENT_HALF;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [CW-1:0] BELL_LD = CW'(BELL_CYC);
    localparam logic [HW-1:0] TONE_H  = HW'(TONE_HALF);
    localparam logic [HW-1:0] ACC_H   = HW'(ACCENT_HALF);

    logic [CW-1:0] bell_cnt;
    logic [HW-1:0] tone_cnt;
    logic [HW-1:0] half;

    // a start reloads the burst (restart, never extend); the divider toggles bell until the burst runs out
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bell_cnt <= '0;
            tone_cnt <= '0;
            half     <= '0;
            bell     <= 1'b0;
        end else if (start) begin
            bell_cnt <= BELL_LD;
            tone_cnt <= '0;
            half     <= hi ? ACC_H : TONE_H;
            bell     <= 1'b1;
        end else if (bell_cnt != '0) begin
            bell_cnt <= bell_cnt - 1'b1;
            if (bell_cnt == CW'(1)) begin
                bell <= 1'b0;
            end else if (tone_cnt + 1'b1 == half) begin
                tone_cnt <= '0;
                bell     <= ~bell;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: turns a BPM value into beat instants, tracks bar position and gates the bell tone
module beat_sequencer
    import beat_sequencer_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BPM_MIN     = BPM_MIN_DEF,
    parameter int BPM_MAX     = BPM_MAX_DEF,
    parameter int BELL_CYC    = CLK_HZ / 20,
    parameter int TONE_HALF   = CLK_HZ / 2000,
    parameter int ACCENT_HALF = CLK_HZ / 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] speed,
    input  logic       play,
    input  logic [3:0] beats_per_bar,
    output logic       bell,
    output logic       beat_tick,
    output logic       accent,
    output logic [3:0] beat_idx,
    output logic       running
);

    localparam logic [ACC_W:0] THRESH = (ACC_W + 1)'(64'd60 * 64'(CLK_HZ));
    localparam logic [7:0] BMIN = 8'(BPM_MIN);
    localparam logic [7:0] BMAX = 8'(BPM_MAX);

    state_t state, state_n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [7:0]       bpm_c;
    logic [3:0]       pos;
    logic [3:0]       bpb_lat;
    logic [3:0]       strike;
    logic [3:0]       bar_len;
    logic             acc_hit;
    logic             beat_ev;
    logic             stop;
    logic             wrap;

    // tempo clamp and one accumulator step, both evaluated every cycle
    always_comb begin
        bpm_c   = (speed < BMIN) ? BMIN : (speed > BMAX) ? BMAX : speed;
        sum     = {1'b0, acc} + (ACC_W + 1)'(bpm_c);
        acc_hit = sum >= THRESH;
    end

    // START always strikes beat 0 of a freshly latched bar; otherwise strike the pending position
    always_comb begin
        strike  = (state == START) ? 4'd0 : pos;
        bar_len = (state == START) ? sanitize_bpb(beats_per_bar) : bpb_lat;
        wrap    = strike == bar_len - 1'b1;
    end

    // next state and beat event; a stop in RUN suppresses any coincident accumulator beat
    always_comb begin
        state_n = state;
        beat_ev = 1'b0;
        stop    = 1'b0;
        case (state)
            IDLE:  state_n = play ? START : IDLE;
            START: begin
                state_n = RUN;
                beat_ev = 1'b1;
            end
            RUN: begin
                state_n = play ? RUN : IDLE;
                stop    = ~play;
                beat_ev = play & acc_hit;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // phase accumulator: zeroed on START, steps by the clamped tempo while running
    always_ff @(posedge clk) begin
        if (rst || state == START) acc <= '0;
        else if (state == RUN && play) acc <= ACC_W'(acc_hit ? sum - THRESH : sum);
    end

    // registered beat outputs; bar length only reloads at the bar boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_tick <= 1'b0;
            accent    <= 1'b0;
            beat_idx  <= 4'd0;
            pos       <= 4'd0;
            bpb_lat   <= 4'd1;
        end else begin
            beat_tick <= beat_ev;
            accent    <= beat_ev && strike == 4'd0;
            if (beat_ev) begin
                beat_idx <= strike;
                pos      <= wrap ? 4'd0 : strike + 4'd1;
                if (wrap || state == START) bpb_lat <= sanitize_bpb(beats_per_bar);
            end
        end
    end

    assign running = state == RUN;

    beat_sequencer_bell_tone_gen #(
        .BELL_CYC   (BELL_CYC),
        .TONE_HALF  (TONE_HALF),
        .ACCENT_HALF(ACCENT_HALF)
    ) bell_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .start(beat_ev),
        .clr  (stop),
        .hi   (strike == 4'd0),
        .bell (bell)
    );

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: randomized scoreboard bench against a behavioural metronome model
module tb_beat_sequencer;

    localparam int CLK_HZ      = 1000;
    localparam int BELL_CYC    = 50;
    localparam int TONE_HALF   = 5;
    localparam int ACCENT_HALF = 2;
    localparam longint TH      = 60 * CLK_HZ;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play = 1'b0;
    logic [7:0] speed = 8'd60;
    logic [3:0] beats_per_bar = 4'd4;
    logic       bell, beat_tick, accent, running;
    logic [3:0] beat_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beat_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .BELL_CYC   (BELL_CYC),
        .TONE_HALF  (TONE_HALF),
        .ACCENT_HALF(ACCENT_HALF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .speed        (speed),
        .play         (play),
        .beats_per_bar(beats_per_bar),
        .bell         (bell),
        .beat_tick    (beat_tick),
        .accent       (accent),
        .beat_idx     (beat_idx),
        .running      (running)
    );

    typedef struct {
        int c;
        int idx;
        bit acc;
    } beat_t;

    beat_t q[$];

    // reference model: beats are counted as whole multiples of THRESH in the running BPM total
    int     cyc = 0;
    bit     on = 1'b0;
    bit     pend = 1'b0;
    longint total = 0;
    int     bar = 1;
    int     pos = 0;
    int     shown = 0;
    int     bt = -1;
    int     bhalf = TONE_HALF;

    function automatic int clampf(input int s);
        return s < 30 ? 30 : s > 250 ? 250 : s;
    endfunction

    function automatic int sanf(input int b);
        return b == 0 ? 1 : b > 9 ? 9 : b;
    endfunction

    function automatic bit beat_due();
        return on && play && ((total + clampf(int'(speed))) / TH) != (total / TH);
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic strike();
        q.push_back('{cyc, pos, pos == 0});
        shown = pos;
        bt    = cyc;
        bhalf = (pos == 0) ? ACCENT_HALF : TONE_HALF;
        pos   = pos + 1;
        if (pos == bar) begin
            pos = 0;
            bar = sanf(int'(beats_per_bar));
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            on    = 1'b0;
            pend  = 1'b0;
            shown = 0;
            pos   = 0;
            bt    = -1;
        end else if (pend) begin
            pend  = 1'b0;
            on    = 1'b1;
            total = 0;
            pos   = 0;
            bar   = sanf(int'(beats_per_bar));
            strike();
        end else if (on) begin
            if (!play) begin
                on = 1'b0;
                bt = -1;
            end else begin
                if (beat_due()) strike();
                total = total + clampf(int'(speed));
            end
        end else if (play) begin
            pend = 1'b1;
        end
    end

    // monitor: pops an expected beat whenever the DUT ticks, and checks the steady outputs every cycle
    always @(negedge clk) begin
        beat_t e;
        int    k;
        bit    eb;
        if (beat_tick) begin
            check(q.size() != 0, "unexpected_tick", cyc, -1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check(e.c == cyc, "tick_cycle", cyc, e.c);
                check(accent == e.acc, "accent", accent, e.acc);
                check(int'(beat_idx) == e.idx, "tick_idx", beat_idx, e.idx);
            end
        end else begin
            check(accent == 1'b0, "accent_without_tick", accent, 0);
            if (q.size() != 0 && q[0].c <= cyc) begin
                check(beat_tick == 1'b1, "missed_tick", beat_tick, 1);
                void'(q.pop_front());
            end
        end
        k  = cyc - bt;
        eb = (bt >= 0 && k < BELL_CYC) ? ((k / bhalf) % 2 == 0) : 1'b0;
        check(bell == eb, "bell", bell, eb);
        check(running == on, "running", running, on);
        check(int'(beat_idx) == shown, "beat_idx", beat_idx, shown);
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idx(input int v);
        int n = 0;
        while (shown != v && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(shown == v, "wait_idx_timeout", shown, v);
    endtask

    task automatic wait_beat();
        int n = 0;
        while (!beat_due() && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(beat_due(), "wait_beat_timeout", n, 0);
    endtask

    task automatic wait_burst(input int d);
        int n = 0;
        while (!(bt >= 0 && cyc - bt == d) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(bt >= 0 && cyc - bt == d, "wait_burst_timeout", n, 0);
    endtask

    initial begin
        run(4);
        rst = 1'b0;
        play = 1'b1;
        run(4500);
        speed = 8'd15;
        run(4100);
        speed = 8'd255;
        run(1000);
        wait_idx(1);
        beats_per_bar = 4'd3;
        run(240 * 7);
        beats_per_bar = 4'd0;
        run(1000);
        beats_per_bar = 4'd12;
        run(240 * 11);
        beats_per_bar = 4'd4;
        wait_beat();
        play = 1'b0;
        run(5);
        play = 1'b1;
        run(600);
        wait_burst(10);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(600);
        repeat (60) begin
            speed = 8'($urandom_range(0, 255));
            beats_per_bar = 4'($urandom_range(0, 15));
            play = $urandom_range(0, 7) != 0;
            run($urandom_range(1, 500));
        end
        play = 1'b0;
        run(5);
        check(q.size() == 0, "queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
